quad_encoder_gen: RTL and testbench

- Generates quadrature A/B signals that emulate a motor shaft encoder at a programmable edge rate and direction.
- It is the transmit side of the encoder interface. It drives the decoder/RPM path in closed-loop benches, and drives the motor-board test header.
- It also keeps a signed edge position and an index output that pulses once per revolution.

---
 rtl/quad_encoder_gen_pkg.sv | 46 ++++
 rtl/quad_encoder_gen_if.sv | 32 +++
 rtl/quad_step_timer.sv | 84 ++++++++
 rtl/quad_encoder_gen.sv | 85 ++++++++
 tb/tb_quad_encoder_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_gen_pkg
//  Description : Shared quadrature state encoding, direction constants and
//                the one-step sequence function.
//  Revision    : 1.0 - initial release
// ============================================================================
package quad_encoder_gen_pkg;

    // Quadrature state encoded as {a, b}.
    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_01 = 2'b01,
        QS_11 = 2'b11,
        QS_10 = 2'b10
    } quad_state_t;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // Forward: 00 -> 10 -> 11 -> 01 -> 00 (A rises while B is low).
    // Reverse walks the same ring backwards, so a reversal never skips a state.
    function automatic quad_state_t next_quad(input quad_state_t state,
                                              input logic        dir);
        quad_state_t nxt;
        nxt = state;
        if (dir == DIR_CW) begin
            case (state)
                QS_00:   nxt = QS_10;
                QS_10:   nxt = QS_11;
                QS_11:   nxt = QS_01;
                default: nxt = QS_00;
            endcase
        end else begin
            case (state)
                QS_00:   nxt = QS_01;
                QS_01:   nxt = QS_11;
                QS_11:   nxt = QS_10;
                default: nxt = QS_00;
            endcase
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_encoder_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_gen_if
//  Description : Control and encoder-output bundle of the quadrature
//                generator. The master drives settings; the slave is the
//                generator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface quad_encoder_gen_if #(
    parameter int DIV_W = 16,
    parameter int POS_W = 16
);
    logic             en;
    logic             load;
    logic [DIV_W-1:0] step_div;
    logic             dir;
    logic             a;
    logic             b;
    logic             idx;
    logic [POS_W-1:0] position;

    modport master (
        output en, load, step_div, dir,
        input  a, b, idx, position
    );

    modport slave (
        input  en, load, step_div, dir,
        output a, b, idx, position
    );
endinterface
`default_nettype wire

// File: rtl/quad_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : quad_step_timer
//  Description : Step-period divider with shadow/active settings. New settings
//                wait in the shadow registers until a safe transfer point
//                (terminal count, disabled, or stopped).
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_step_timer #(
    parameter int DIV_W = 16
) (
    input  wire logic             cclk,
    input  wire logic             rstb,
    input  wire logic             en_i,
    input  wire logic             load_i,
    input  wire logic [DIV_W-1:0] step_div_i,
    input  wire logic             dir_i,
    output logic                  step_pulse_o,
    output logic                  active_dir_o
);

    logic [DIV_W-1:0] shadow_div_q, shadow_div_d;
    logic             shadow_dir_q, shadow_dir_d;
    logic             pending_q,    pending_d;
    logic [DIV_W-1:0] active_div_q, active_div_d;
    logic             active_dir_q, active_dir_d;
    logic [DIV_W-1:0] timer_q,      timer_d;
    logic             step;
    logic             pend_now;
    logic             running;

    // Next-state: a load in the same cycle as a transfer point is forwarded,
    // so the current step still uses the old settings and the new ones take
    // effect from the very next cycle.
    always_comb begin
        shadow_div_d = load_i ? step_div_i : shadow_div_q;
        shadow_dir_d = load_i ? dir_i      : shadow_dir_q;
        pend_now     = pending_q | load_i;
        running      = en_i && (active_div_q != '0);
        step         = running && (timer_q == active_div_q - DIV_W'(1));

        active_div_d = active_div_q;
        active_dir_d = active_dir_q;
        pending_d    = pend_now;
        timer_d      = timer_q;

        if (step) begin
            timer_d = '0;
        end else if (running) begin
            timer_d = timer_q + DIV_W'(1);
        end

        if (pend_now && (step || !en_i || (active_div_q == '0))) begin
            active_div_d = shadow_div_d;
            active_dir_d = shadow_dir_d;
            pending_d    = 1'b0;
            timer_d      = '0;
        end
    end

    // Settings and divider registers.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            shadow_div_q <= '0;
            shadow_dir_q <= 1'b0;
            pending_q    <= 1'b0;
            active_div_q <= '0;
            active_dir_q <= 1'b0;
            timer_q      <= '0;
        end else begin
            shadow_div_q <= shadow_div_d;
            shadow_dir_q <= shadow_dir_d;
            pending_q    <= pending_d;
            active_div_q <= active_div_d;
            active_dir_q <= active_dir_d;
            timer_q      <= timer_d;
        end
    end

    assign step_pulse_o = step;
    assign active_dir_o = active_dir_q;

endmodule
`default_nettype wire

// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_gen
//  Description : Quadrature A/B encoder emulator with programmable edge rate
//                and direction, signed edge position and once-per-revolution
//                index output.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int POS_W     = 16,
    parameter int CPR_EDGES = 48
) (
    input  wire logic            cclk,
    input  wire logic            rstb,
    quad_encoder_gen_if.slave    bus
);

    localparam int REV_W = (CPR_EDGES > 1) ? $clog2(CPR_EDGES) : 1;
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR_EDGES - 1);

    logic        step_pulse;
    logic        active_dir;

    quad_state_t      state_q,    state_d;
    logic [POS_W-1:0] position_q, position_d;
    logic [REV_W-1:0] rev_edge_q, rev_edge_d;
    logic             idx_q,      idx_d;

    quad_step_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .cclk         (cclk),
        .rstb         (rstb),
        .en_i         (bus.en),
        .load_i       (bus.load),
        .step_div_i   (bus.step_div),
        .dir_i        (bus.dir),
        .step_pulse_o (step_pulse),
        .active_dir_o (active_dir)
    );

    // Next-state: advance quadrature state, position and revolution edge on
    // each step; idx is precomputed so it lines up with the registered edge.
    always_comb begin
        state_d    = state_q;
        position_d = position_q;
        rev_edge_d = rev_edge_q;
        if (step_pulse) begin
            state_d = next_quad(state_q, active_dir);
            if (active_dir == DIR_CW) begin
                position_d = position_q + POS_W'(1);
                rev_edge_d = (rev_edge_q == REV_MAX) ? '0 : rev_edge_q + REV_W'(1);
            end else begin
                position_d = position_q - POS_W'(1);
                rev_edge_d = (rev_edge_q == '0) ? REV_MAX : rev_edge_q - REV_W'(1);
            end
        end
        idx_d = (rev_edge_d == '0);
    end

    // Output-facing registers; a/b come straight from flops so they never glitch.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= QS_00;
            position_q <= '0;
            rev_edge_q <= '0;
            idx_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            rev_edge_q <= rev_edge_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.a        = state_q[1];
    assign bus.b        = state_q[0];
    assign bus.idx      = idx_q;
    assign bus.position = position_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_encoder_gen
//  Description : Self-checking bench for quad_encoder_gen with a behavioural
//                reference model and directed plus random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_gen;

    localparam int DIV_W = 16;
    localparam int POS_W = 16;
    localparam int CPR   = 48;

    logic cclk = 1'b0;
    logic rstb = 1'b0;

    quad_encoder_gen_if #(.DIV_W(DIV_W), .POS_W(POS_W)) bus ();

    quad_encoder_gen #(
        .DIV_W     (DIV_W),
        .POS_W     (POS_W),
        .CPR_EDGES (CPR)
    ) dut (
        .cclk (cclk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 cclk = ~cclk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase is an index into the forward ring of {a,b}.
    logic [1:0] seq [4];
    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    end

    int m_phase = 0, m_pos = 0, m_rev = 0;
    int m_adiv = 0, m_sdiv = 0, m_elapsed = 0;
    bit m_adir = 0, m_sdir = 0, m_pend = 0;
    bit m_stp, m_pnow, m_sdir_now;
    int m_sdiv_now;

    always @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            m_phase = 0; m_pos = 0; m_rev = 0;
            m_adiv = 0; m_sdiv = 0; m_elapsed = 0;
            m_adir = 0; m_sdir = 0; m_pend = 0;
        end else begin
            m_stp      = bus.en && (m_adiv != 0) && (m_elapsed + 1 == m_adiv);
            m_pnow     = m_pend || bus.load;
            m_sdiv_now = bus.load ? int'(bus.step_div) : m_sdiv;
            m_sdir_now = bus.load ? bus.dir : m_sdir;
            if (m_stp) begin
                if (!m_adir) begin
                    m_phase = (m_phase + 1) % 4;
                    m_pos   = (m_pos + 1) % 65536;
                    m_rev   = (m_rev + 1) % CPR;
                end else begin
                    m_phase = (m_phase + 3) % 4;
                    m_pos   = (m_pos + 65535) % 65536;
                    m_rev   = (m_rev + CPR - 1) % CPR;
                end
                m_elapsed = 0;
            end else if (bus.en && m_adiv != 0) begin
                m_elapsed = m_elapsed + 1;
            end
            m_sdiv = m_sdiv_now;
            m_sdir = m_sdir_now;
            if (m_pnow && (m_stp || !bus.en || m_adiv == 0)) begin
                m_adiv    = m_sdiv_now;
                m_adir    = m_sdir_now;
                m_pend    = 0;
                m_elapsed = 0;
            end else begin
                m_pend = m_pnow;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge cclk) begin
        if (chk_on) begin
            check("ab",       32'({bus.a, bus.b}), 32'(seq[m_phase]));
            check("idx",      32'(bus.idx),        32'(m_rev == 0));
            check("position", 32'(bus.position),   32'(m_pos));
        end
    end

    task automatic load_set(input int div, input bit d);
        @(negedge cclk);
        bus.load = 1'b1; bus.step_div = DIV_W'(div); bus.dir = d;
        @(negedge cclk);
        bus.load = 1'b0;
    endtask

    // Load while disabled for one cycle so the settings apply immediately.
    task automatic load_dis(input int div, input bit d);
        @(negedge cclk);
        bus.en = 1'b0; bus.load = 1'b1; bus.step_div = DIV_W'(div); bus.dir = d;
        @(negedge cclk);
        bus.load = 1'b0; bus.en = 1'b1;
    endtask

    task automatic apply_reset();
        @(posedge cclk);
        #2 rstb = 1'b0;
        bus.load = 1'b0;
        @(posedge cclk);
        @(posedge cclk);
        #2 rstb = 1'b1;
        @(negedge cclk);
    endtask

    logic [1:0] fwd_lit [4];
    int a_rises;
    logic prev_a;

    initial begin
        fwd_lit[0] = 2'b10; fwd_lit[1] = 2'b11; fwd_lit[2] = 2'b01; fwd_lit[3] = 2'b00;
        bus.en = 1'b0; bus.load = 1'b0; bus.step_div = '0; bus.dir = 1'b0;

        // Reset, then idle with en high and no load.
        repeat (3) @(posedge cclk);
        #2 rstb = 1'b1;
        @(negedge cclk);
        chk_on = 1'b1;
        check("rst_ab",  32'({bus.a, bus.b}), 32'h0);
        check("rst_pos", 32'(bus.position),   32'h0);
        check("rst_idx", 32'(bus.idx),        32'h1);
        bus.en = 1'b1;
        repeat (100) @(negedge cclk);
        check("idle_ab",  32'({bus.a, bus.b}), 32'h0);
        check("idle_pos", 32'(bus.position),   32'h0);

        // Forward run at 4 cycles per transition.
        load_set(4, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            repeat (4) @(negedge cclk);
            check("fwd_ab",  32'({bus.a, bus.b}), 32'(fwd_lit[(k - 1) % 4]));
            check("fwd_pos", 32'(bus.position),   32'(k));
        end
        check("fwd_idx", 32'(bus.idx), 32'h0);

        // Reversal from state 11.
        load_dis(4, 1'b1);
        repeat (4) @(negedge cclk);
        check("rev_ab1",  32'({bus.a, bus.b}), 32'h2);
        check("rev_pos1", 32'(bus.position),   32'd9);
        repeat (4) @(negedge cclk);
        check("rev_ab2",  32'({bus.a, bus.b}), 32'h0);
        check("rev_pos2", 32'(bus.position),   32'd8);

        // Stopped, then resume at 2 cycles per transition.
        load_dis(0, 1'b0);
        repeat (50) @(negedge cclk);
        check("stop_pos", 32'(bus.position),   32'd8);
        check("stop_ab",  32'({bus.a, bus.b}), 32'h0);
        load_set(2, 1'b0);
        repeat (10) @(negedge cclk);
        check("div2_pos", 32'(bus.position),   32'd13);
        check("div2_ab",  32'({bus.a, bus.b}), 32'h2);

        // A rising-edge rate: 400 cycles at div 5 -> 80 steps -> 20 rises.
        load_dis(5, 1'b0);
        a_rises = 0;
        prev_a  = bus.a;
        repeat (400) begin
            @(negedge cclk);
            if (bus.a && !prev_a) a_rises++;
            prev_a = bus.a;
        end
        check("a_rate", 32'(a_rises), 32'd20);

        // Load coinciding with terminal count.
        apply_reset();
        load_dis(2, 1'b0);
        @(negedge cclk);
        @(negedge cclk);
        check("coin_p1", 32'(bus.position), 32'd1);
        @(negedge cclk);
        bus.load = 1'b1; bus.step_div = DIV_W'(3); bus.dir = 1'b0;
        @(negedge cclk);
        bus.load = 1'b0;
        check("coin_old", 32'(bus.position), 32'd2);
        @(negedge cclk);
        @(negedge cclk);
        check("coin_hold", 32'(bus.position), 32'd2);
        @(negedge cclk);
        check("coin_new", 32'(bus.position), 32'd3);

        // 48 forward steps wrap the revolution.
        apply_reset();
        load_dis(1, 1'b0);
        repeat (48) @(negedge cclk);
        bus.en = 1'b0;
        check("wrapf_pos", 32'(bus.position),   32'd48);
        check("wrapf_idx", 32'(bus.idx),        32'h1);
        check("wrapf_ab",  32'({bus.a, bus.b}), 32'h0);

        // One reverse step from reset.
        apply_reset();
        load_dis(1, 1'b1);
        @(negedge cclk);
        bus.en = 1'b0;
        check("wrapr_pos", 32'(bus.position),   32'hFFFF);
        check("wrapr_idx", 32'(bus.idx),        32'h0);
        check("wrapr_ab",  32'({bus.a, bus.b}), 32'h1);

        // Asynchronous reset in the middle of a step_div=1 run.
        apply_reset();
        load_dis(1, 1'b0);
        repeat (7) @(negedge cclk);
        @(posedge cclk);
        #2 rstb = 1'b0;
        #1;
        check("arst_ab",  32'({bus.a, bus.b}), 32'h0);
        check("arst_pos", 32'(bus.position),   32'h0);
        check("arst_idx", 32'(bus.idx),        32'h1);
        @(posedge cclk);
        #2 rstb = 1'b1;
        repeat (20) @(negedge cclk);
        check("post_rst_pos", 32'(bus.position),   32'h0);
        check("post_rst_ab",  32'({bus.a, bus.b}), 32'h0);

        // Random loads, directions and enable gaps.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge cclk);
            bus.load = ($urandom_range(0, 11) == 0);
            if (bus.load) begin
                bus.step_div = DIV_W'($urandom_range(0, 6));
                bus.dir      = 1'($urandom_range(0, 1));
            end
            bus.en = ($urandom_range(0, 7) != 0);
        end
        @(negedge cclk);
        bus.load = 1'b0;
        repeat (5) @(negedge cclk);
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
